// File: rtl/count_display_mux.sv
// Binary count to 2-digit multiplexed common-anode seven-segment display driver.
// Latency: a count change shows on seg WIDTH+3 edges after it reaches cnt_q.
// No backpressure: count changes during a conversion are picked up by the next one.
module count_display_mux #(
    parameter int WIDTH       = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    output logic [6:0]       seg,
    output logic [1:0]       an,
    output logic             dp,
    output logic             busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam int SW = WIDTH + 8;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] shown_bin;
    logic [WIDTH-1:0] conv_val;
    logic [3:0]       disp_tens;
    logic [3:0]       disp_ones;
    logic             disp_dash;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [SW-1:0]    sr;
    logic [SW-1:0]    adj;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    refresh_cnt;
    logic             digit_sel;
    logic [6:0]       tens_code;
    logic [6:0]       ones_code;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    assign dp = 1'b1;

    // Double-dabble correction: add 3 to each BCD nibble that is 5 or more before the shift.
    always_comb begin
        adj = sr;
        if (adj[WIDTH+3:WIDTH] >= 4'd5)
            adj[WIDTH+3:WIDTH] = adj[WIDTH+3:WIDTH] + 4'd3;
        if (adj[WIDTH+7:WIDTH+4] >= 4'd5)
            adj[WIDTH+7:WIDTH+4] = adj[WIDTH+7:WIDTH+4] + 4'd3;
    end

    // Conversion FSM next state; one CONV cycle per input bit.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cnt_q != shown_bin) state_nxt = S_CONV;
            S_CONV:   if (bit_cnt == BW'(WIDTH - 1)) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Input sampling, conversion datapath and atomic commit of the digit pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            shown_bin <= '0;
            conv_val  <= '0;
            disp_tens <= 4'd0;
            disp_ones <= 4'd0;
            disp_dash <= 1'b0;
            state     <= S_IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            cnt_q <= count;
            state <= state_nxt;
            // busy stays up through the commit edge so it drops when seg shows the new value
            busy  <= (state_nxt != S_IDLE) || (state == S_COMMIT);
            case (state)
                S_IDLE: begin
                    if (cnt_q != shown_bin) begin
                        sr       <= {8'd0, cnt_q};
                        conv_val <= cnt_q;
                        bit_cnt  <= '0;
                    end
                end
                S_CONV: begin
                    sr      <= {adj[SW-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_COMMIT: begin
                    disp_tens <= sr[SW-1:SW-4];
                    disp_ones <= sr[SW-5:SW-8];
                    disp_dash <= (8'(conv_val) > 8'd99);
                    shown_bin <= conv_val;
                end
                default: ;
            endcase
        end
    end

    // Digit codes; dash overrides leading-zero blanking.
    always_comb begin
        ones_code = disp_dash ? SEG_DASH : seg_code(disp_ones);
        if (disp_dash)
            tens_code = SEG_DASH;
        else if ((BLANK_LZ != 0) && (disp_tens == 4'd0))
            tens_code = SEG_BLANK;
        else
            tens_code = seg_code(disp_tens);
    end

    // Refresh divider and registered anode/segment drive, updated together.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= 2'b11;
        end else begin
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_sel   <= ~digit_sel;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            seg <= digit_sel ? tens_code : ones_code;
            an  <= digit_sel ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: tb/tb_count_display_mux.sv
module tb_count_display_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] c4, c0;
    logic [6:0] c7;
    logic [6:0] seg4, seg7, seg0;
    logic [1:0] an4, an7, an0;
    logic       dp4, dp7, dp0;
    logic       busy4, busy7, busy0;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    count_display_mux #(.WIDTH(4), .REFRESH_DIV(4), .BLANK_LZ(1)) u4 (
        .clk(clk), .reset(reset), .count(c4), .seg(seg4), .an(an4), .dp(dp4), .busy(busy4));
    count_display_mux #(.WIDTH(7), .REFRESH_DIV(4), .BLANK_LZ(1)) u7 (
        .clk(clk), .reset(reset), .count(c7), .seg(seg7), .an(an7), .dp(dp7), .busy(busy7));
    count_display_mux #(.WIDTH(4), .REFRESH_DIV(4), .BLANK_LZ(0)) u0 (
        .clk(clk), .reset(reset), .count(c0), .seg(seg0), .an(an0), .dp(dp0), .busy(busy0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get_out(input int which, output logic [6:0] s, output logic [1:0] a, output logic b);
        case (which)
            7:       begin s = seg7; a = an7; b = busy7; end
            0:       begin s = seg0; a = an0; b = busy0; end
            default: begin s = seg4; a = an4; b = busy4; end
        endcase
    endtask

    // Two edges to let the change reach the FSM, then wait for busy low (bounded).
    task automatic wait_idle(input int which, input int bound, output int cycles, output bit ok);
        logic [6:0] s; logic [1:0] a; logic b;
        tick(); tick();
        cycles = 2;
        ok = 1'b0;
        while (cycles < bound) begin
            get_out(which, s, a, b);
            if (!b) begin ok = 1'b1; break; end
            tick();
            cycles++;
        end
    endtask

    // Collect the segment code shown for each digit over one refresh frame.
    task automatic capture(input int which, output logic [6:0] ones, output logic [6:0] tens, output bit ok);
        logic [6:0] s; logic [1:0] a; logic b;
        bit go = 0, gt = 0;
        ones = 'x; tens = 'x;
        for (int i = 0; i < 12 && !(go && gt); i++) begin
            tick();
            get_out(which, s, a, b);
            if (a == 2'b10) begin ones = s; go = 1; end
            if (a == 2'b01) begin tens = s; gt = 1; end
        end
        ok = go && gt;
    endtask

    task automatic test_reset();
        total++; if (an4 !== 2'b11) $display("FAIL reset_an got=%b exp=11", an4); else pass_cnt++;
        total++; if (seg4 !== 7'b1111111) $display("FAIL reset_seg got=%b exp=1111111", seg4); else pass_cnt++;
        total++; if (busy4 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy4); else pass_cnt++;
        total++; if (dp4 !== 1'b1) $display("FAIL reset_dp got=%b exp=1", dp4); else pass_cnt++;
        total++; if (an7 !== 2'b11) $display("FAIL reset_an7 got=%b exp=11", an7); else pass_cnt++;
    endtask

    task automatic test_refresh();
        reset = 1'b0;
        tick();
        total++; if (an4 !== 2'b10) $display("FAIL rel_an got=%b exp=10", an4); else pass_cnt++;
        total++; if (seg4 !== 7'b1000000) $display("FAIL rel_seg got=%b exp=1000000", seg4); else pass_cnt++;
        tick(); tick(); tick();
        total++; if (an4 !== 2'b10) $display("FAIL dwell_ones_end got=%b exp=10", an4); else pass_cnt++;
        tick();
        total++; if (an4 !== 2'b01) $display("FAIL tens_an got=%b exp=01", an4); else pass_cnt++;
        total++; if (seg4 !== 7'b1111111) $display("FAIL tens_blank got=%b exp=1111111", seg4); else pass_cnt++;
        tick(); tick(); tick();
        total++; if (an4 !== 2'b01) $display("FAIL dwell_tens_end got=%b exp=01", an4); else pass_cnt++;
        tick();
        total++; if (an4 !== 2'b10) $display("FAIL alt_an got=%b exp=10", an4); else pass_cnt++;
        total++; if (busy4 !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy4); else pass_cnt++;
    endtask

    task automatic test_latency();
        c4 = 4'd7;
        tick();
        total++; if (busy4 !== 1'b0) $display("FAIL lat_busy_k got=%b exp=0", busy4); else pass_cnt++;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++; if (busy4 !== 1'b1) $display("FAIL lat_busy_k+%0d got=%b exp=1", i, busy4); else pass_cnt++;
        end
        tick();
        total++; if (busy4 !== 1'b0) $display("FAIL lat_busy_k+7 got=%b exp=0", busy4); else pass_cnt++;
        if (an4 == 2'b10) begin
            total++; if (seg4 !== 7'b1111000) $display("FAIL lat_seg7 got=%b exp=1111000", seg4); else pass_cnt++;
        end else begin
            total++; if (seg4 !== 7'b1111111) $display("FAIL lat_tens7 got=%b exp=1111111", seg4); else pass_cnt++;
        end
    endtask

    task automatic test_nminus1_wrap();
        logic [6:0] o, t; bit ok; int cyc;
        c4 = 4'd10;
        wait_idle(4, 20, cyc, ok);
        capture(4, o, t, ok);
        total++; if (!ok || o !== 7'b1000000) $display("FAIL n1_ones got=%b exp=1000000", o); else pass_cnt++;
        total++; if (!ok || t !== 7'b1111001) $display("FAIL n1_tens got=%b exp=1111001", t); else pass_cnt++;
        c4 = 4'd0;
        wait_idle(4, 20, cyc, ok);
        capture(4, o, t, ok);
        total++; if (!ok || o !== 7'b1000000) $display("FAIL upwrap_ones got=%b exp=1000000", o); else pass_cnt++;
        total++; if (!ok || t !== 7'b1111111) $display("FAIL upwrap_tens got=%b exp=1111111", t); else pass_cnt++;
        c4 = 4'd10;
        wait_idle(4, 20, cyc, ok);
        capture(4, o, t, ok);
        total++; if (!ok || t !== 7'b1111001) $display("FAIL dnwrap_tens got=%b exp=1111001", t); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] o, t; bit ok; int el;
        c4 = 4'd3;
        tick(); tick();
        c4 = 4'd5;
        tick();
        c4 = 4'd9;
        tick();
        el = 4;
        total++; if (busy4 !== 1'b1) $display("FAIL b2b_busy_mid got=%b exp=1", busy4); else pass_cnt++;
        // Ignore the one-cycle gap between the first commit and the restart.
        while (el < 30) begin
            if (!busy4) begin
                tick(); el++;
                if (!busy4) break;
            end else begin
                tick(); el++;
            end
        end
        total++; if (el - 1 > 16) $display("FAIL b2b_time got=%0d exp<=16", el - 1); else pass_cnt++;
        capture(4, o, t, ok);
        total++; if (!ok || o !== 7'b0010000) $display("FAIL b2b_ones got=%b exp=0010000", o); else pass_cnt++;
        total++; if (!ok || t !== 7'b1111111) $display("FAIL b2b_tens got=%b exp=1111111", t); else pass_cnt++;
        total++; if (busy4 !== 1'b0) $display("FAIL b2b_busy_end got=%b exp=0", busy4); else pass_cnt++;
    endtask

    task automatic test_wide();
        logic [6:0] o, t; bit ok; int cyc;
        logic [6:0] vals [3];
        logic [6:0] exp_o [3];
        logic [6:0] exp_t [3];
        vals[0] = 7'd127; exp_o[0] = 7'b0111111; exp_t[0] = 7'b0111111;
        vals[1] = 7'd100; exp_o[1] = 7'b0111111; exp_t[1] = 7'b0111111;
        vals[2] = 7'd99;  exp_o[2] = 7'b0010000; exp_t[2] = 7'b0010000;
        for (int i = 0; i < 3; i++) begin
            c7 = vals[i];
            wait_idle(7, 30, cyc, ok);
            total++; if (!ok) $display("FAIL w7_timeout_%0d got=busy exp=idle", vals[i]); else pass_cnt++;
            capture(7, o, t, ok);
            total++; if (!ok || o !== exp_o[i]) $display("FAIL w7_ones_%0d got=%b exp=%b", vals[i], o, exp_o[i]); else pass_cnt++;
            total++; if (!ok || t !== exp_t[i]) $display("FAIL w7_tens_%0d got=%b exp=%b", vals[i], t, exp_t[i]); else pass_cnt++;
        end
    endtask

    task automatic test_no_blank();
        logic [6:0] o, t; bit ok; int cyc;
        c0 = 4'd4;
        wait_idle(0, 20, cyc, ok);
        capture(0, o, t, ok);
        total++; if (!ok || t !== 7'b1000000) $display("FAIL nolz_tens got=%b exp=1000000", t); else pass_cnt++;
        total++; if (!ok || o !== 7'b0011001) $display("FAIL nolz_ones got=%b exp=0011001", o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        c4 = 4'd8;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        total++; if (an4 !== 2'b11) $display("FAIL rmid_an got=%b exp=11", an4); else pass_cnt++;
        total++; if (busy4 !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy4); else pass_cnt++;
        reset = 1'b0;
        tick();
        total++; if (an4 !== 2'b10 || seg4 !== 7'b1000000) $display("FAIL rmid_r1 got=%b/%b exp=10/1000000", an4, seg4); else pass_cnt++;
        tick(); tick(); tick();
        total++; if (an4 !== 2'b10 || seg4 !== 7'b1000000) $display("FAIL rmid_r4 got=%b/%b exp=10/1000000", an4, seg4); else pass_cnt++;
        tick(); tick(); tick(); tick();
        total++; if (busy4 !== 1'b0) $display("FAIL rmid_busy_r8 got=%b exp=0", busy4); else pass_cnt++;
        total++; if (an4 !== 2'b01 || seg4 !== 7'b1111111) $display("FAIL rmid_r8 got=%b/%b exp=01/1111111", an4, seg4); else pass_cnt++;
        tick();
        total++; if (an4 !== 2'b10 || seg4 !== 7'b0000000) $display("FAIL rmid_r9 got=%b/%b exp=10/0000000", an4, seg4); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        c4 = 4'd0; c7 = 7'd0; c0 = 4'd0;
        tick(); tick(); tick();
        test_reset();
        test_refresh();
        test_latency();
        test_nminus1_wrap();
        test_back_to_back();
        test_wide();
        test_no_blank();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
